// File: rtl/camera_scheduler_pkg.sv
// camera_scheduler_pkg: shared screen geometry constants and scheduler state type
package camera_scheduler_pkg;
    localparam int POS_W       = 14;
    localparam int CAM_W       = 5;
    localparam int SCREEN_H    = 480;
    localparam int MAX_CAM     = 31;
    localparam int MARGIN      = 16;
    localparam int SETTLE_CYC  = 4;
    localparam int ACK_TIMEOUT = 255;
    typedef enum logic [1:0] {IDLE, REQ, SETTLE} cam_state_t;
endpackage

// File: rtl/camera_scheduler_regen_handshake.sv
// camera_scheduler_regen_handshake: regen req/ack handshake with ack timeout and sticky error
module camera_scheduler_regen_handshake
    import camera_scheduler_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic start,
    input  logic regen_ack,
    output logic regen_req,
    output logic done,
    output logic timeout_err
);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
    logic expired;
    assign expired = wait_cnt == TO_W'(ACK_TIMEOUT - 1);
    assign done = regen_req && (regen_ack || expired);
    // raise req on start, drop it on ack or after the timeout window
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            regen_req   <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (start) begin
            regen_req <= 1'b1;
            wait_cnt  <= '0;
        end else if (done) begin
            regen_req <= 1'b0;
            if (!regen_ack) timeout_err <= 1'b1;
        end else if (regen_req) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/camera_scheduler.sv
// camera_scheduler: tracks the 480-line screen the player is on and sequences platform rebuilds
// Optional: define CAMERA_FALL_CNT_EN to add the saturating down-scroll counter output fall_cnt.
module camera_scheduler
    import camera_scheduler_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             char_tick,
    input  logic [POS_W-1:0] abs_char_y,
    input  logic             regen_ack,
    output logic [CAM_W-1:0] camera_y,
    output logic [POS_W-1:0] cam_base,
    output logic             regen_req,
    output logic             scroll_dir,
    output logic             freeze,
    output logic             timeout_err
`ifdef CAMERA_FALL_CNT_EN
    ,
    output logic [7:0]       fall_cnt
`endif
);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    cam_state_t state, state_nx;
    logic [SET_W-1:0] settle_cnt, settle_nx;
    logic [POS_W:0] ext_y, ext_base, top;
    logic go_up, go_down, start, done;
    assign ext_y    = {1'b0, abs_char_y};
    assign ext_base = {1'b0, cam_base};
    assign top      = ext_base + (POS_W+1)'(SCREEN_H + MARGIN);
    assign go_up    = ext_y >= top && camera_y < CAM_W'(MAX_CAM);
    assign go_down  = camera_y != '0 && ext_y + (POS_W+1)'(MARGIN) < ext_base;
    assign start    = state == IDLE && char_tick && (go_up || go_down);
    assign freeze   = state != IDLE;
    camera_scheduler_regen_handshake u_handshake (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .regen_ack   (regen_ack),
        .regen_req   (regen_req),
        .done        (done),
        .timeout_err (timeout_err)
    );
    // state and settle counter registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_nx;
        end
    end
    // next state: IDLE -> REQ on a scroll decision, REQ -> SETTLE on handshake done, SETTLE -> IDLE after the settle window
    always_comb begin
        state_nx  = state;
        settle_nx = settle_cnt;
        if (start) state_nx = REQ;
        if (state == REQ && done) begin
            state_nx  = SETTLE;
            settle_nx = '0;
        end
        if (state == SETTLE) begin
            settle_nx = settle_cnt + 1'b1;
            state_nx  = settle_cnt == SET_W'(SETTLE_CYC - 1) ? IDLE : SETTLE;
        end
    end
    // camera index and base step together by one screen when a scroll starts
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            camera_y   <= '0;
            cam_base   <= '0;
            scroll_dir <= 1'b0;
        end else if (start) begin
            camera_y   <= go_up ? camera_y + 1'b1 : camera_y - 1'b1;
            cam_base   <= go_up ? cam_base + POS_W'(SCREEN_H) : cam_base - POS_W'(SCREEN_H);
            scroll_dir <= go_up;
        end
    end
`ifdef CAMERA_FALL_CNT_EN
    // count down-scroll entries, saturating
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) fall_cnt <= '0;
        else if (start && !go_up && fall_cnt != 8'hFF) fall_cnt <= fall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_camera_scheduler.sv
// tb_camera_scheduler: randomized scoreboard bench for camera_scheduler against a screen-index model
module tb_camera_scheduler;
    import camera_scheduler_pkg::*;
    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             char_tick = 1'b0;
    logic             regen_ack = 1'b0;
    logic [POS_W-1:0] abs_char_y = '0;
    logic [CAM_W-1:0] camera_y;
    logic [POS_W-1:0] cam_base;
    logic             regen_req, scroll_dir, freeze, timeout_err;
`ifdef CAMERA_FALL_CNT_EN
    logic [7:0]       fall_cnt;
`endif
    typedef struct {int cam; int base; int dir; int req_len; int terr; int falls;} exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;
    int m_cam = 0;
    int m_terr = 0;
    int m_falls = 0;

    camera_scheduler dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .char_tick   (char_tick),
        .abs_char_y  (abs_char_y),
        .regen_ack   (regen_ack),
        .camera_y    (camera_y),
        .cam_base    (cam_base),
        .regen_req   (regen_req),
        .scroll_dir  (scroll_dir),
        .freeze      (freeze),
        .timeout_err (timeout_err)
`ifdef CAMERA_FALL_CNT_EN
        ,
        .fall_cnt    (fall_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic check_reset_values();
        check("rst_camera_y", int'(camera_y), 0);
        check("rst_cam_base", int'(cam_base), 0);
        check("rst_regen_req", int'(regen_req), 0);
        check("rst_scroll_dir", int'(scroll_dir), 0);
        check("rst_freeze", int'(freeze), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
`ifdef CAMERA_FALL_CNT_EN
        check("rst_fall_cnt", int'(fall_cnt), 0);
`endif
    endtask

    // model decision for a tick in IDLE: returns +1 up, -1 down, 0 none
    function automatic int decide(input int y);
        int base;
        base = m_cam * SCREEN_H;
        if (y >= base + SCREEN_H + MARGIN && m_cam < MAX_CAM) return 1;
        if (m_cam > 0 && y + MARGIN < base) return -1;
        return 0;
    endfunction

    function automatic void push_expect(input int step, input int k);
        exp_t e;
        m_cam += step;
        if (step < 0) m_falls = m_falls < 255 ? m_falls + 1 : 255;
        if (k == 0) m_terr = 1;
        e = '{m_cam, m_cam * SCREEN_H, step > 0 ? 1 : 0, k == 0 ? ACK_TIMEOUT : k, m_terr, m_falls};
        exp_q.push_back(e);
    endfunction

    task automatic busy_tick(input bit busy);
        if (busy && $urandom_range(0, 2) == 0) begin
            abs_char_y = POS_W'($urandom);
            char_tick = 1'b1;
        end
    endtask

    // one tick in IDLE; k = ack after k req cycles, 0 = never ack
    task automatic round(input int y, input int k, input bit busy);
        int step;
        int n;
        step = decide(y);
        if (step != 0) push_expect(step, k);
        abs_char_y = POS_W'(y);
        char_tick = 1'b1;
        regen_ack = 1'($urandom_range(0, 1));
        @(posedge sys_clk); #1;
        char_tick = 1'b0;
        regen_ack = 1'b0;
        if (step != 0) begin
            n = 1;
            while (regen_req && n < 400) begin
                if (n == k) regen_ack = 1'b1;
                busy_tick(busy);
                @(posedge sys_clk); #1;
                char_tick = 1'b0;
                n++;
            end
            regen_ack = 1'b0;
            check("req_dropped", int'(regen_req), 0);
            n = 0;
            while (freeze && n < 50) begin
                busy_tick(busy);
                @(posedge sys_clk); #1;
                char_tick = 1'b0;
                n++;
            end
            check("freeze_released", int'(freeze), 0);
        end else begin
            repeat (2) @(posedge sys_clk);
            #1;
            check("idle_freeze", int'(freeze), 0);
        end
        check("camera_y", int'(camera_y), m_cam);
        check("cam_base", int'(cam_base), m_cam * SCREEN_H);
    endtask

    // monitor: pops an expectation on each req rise, checks req length and settle length
    initial begin : monitor
        exp_t cur;
        bit prev_req;
        bit settling;
        int req_len;
        int settle_len;
        cur = '{0, 0, 0, 0, 0, 0};
        prev_req = 1'b0;
        settling = 1'b0;
        req_len = 0;
        settle_len = 0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                prev_req = 1'b0;
                settling = 1'b0;
            end else begin
                if (regen_req && !prev_req) begin
                    if (exp_q.size() == 0) check("unexpected_scroll", 1, 0);
                    else begin
                        cur = exp_q.pop_front();
                        check("scroll_camera_y", int'(camera_y), cur.cam);
                        check("scroll_cam_base", int'(cam_base), cur.base);
                        check("scroll_dir", int'(scroll_dir), cur.dir);
                        check("scroll_freeze", int'(freeze), 1);
`ifdef CAMERA_FALL_CNT_EN
                        check("fall_cnt", int'(fall_cnt), cur.falls);
`endif
                    end
                    req_len = 0;
                end
                if (regen_req) req_len++;
                if (!regen_req && prev_req) begin
                    check("req_len", req_len, cur.req_len);
                    check("timeout_err", int'(timeout_err), cur.terr);
                    settling = 1'b1;
                    settle_len = 0;
                end
                if (settling && freeze) settle_len++;
                if (settling && !freeze) begin
                    check("settle_len", settle_len, SETTLE_CYC);
                    settling = 1'b0;
                end
                prev_req = regen_req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int y;
        int k;
        repeat (2) @(posedge sys_clk);
        #1;
        check_reset_values();
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        round(100, 3, 0);
        round(495, 3, 0);
        round(496, 3, 0);
        round(463, 2, 0);
        round(0, 1, 0);
        round(496, 0, 0);
        round(0, 4, 1);
        repeat (4) round(1500, int'($urandom_range(1, 6)), 1);
        repeat (30) round(16383, int'($urandom_range(1, 8)), 1);
        round(16383, 2, 0);
        repeat (60) begin
            y = m_cam * SCREEN_H - 40 + int'($urandom_range(0, 560));
            if (y < 0) y = 0;
            if (y > 16383) y = 16383;
            k = $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 8));
            round(y, k, 1'($urandom_range(0, 1)));
        end
        y = m_cam < MAX_CAM ? (m_cam + 1) * SCREEN_H + 20 : 0;
        push_expect(decide(y), 5);
        abs_char_y = POS_W'(y);
        char_tick = 1'b1;
        @(posedge sys_clk); #1;
        char_tick = 1'b0;
        @(posedge sys_clk); #3;
        check("mid_req_active", int'(regen_req), 1);
        sys_rst_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        m_cam = 0;
        m_terr = 0;
        m_falls = 0;
        round(496, 2, 0);
        round(10, 1, 0);
        round(980, 3, 1);
        round(20, 2, 1);
        repeat (5) @(posedge sys_clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/camera_scheduler.md
Name: camera_scheduler

Overview:
- Decides which 480-line screen ("camera") the player is on, from the character's absolute Y.
- On a screen change it steps camera_y and asks the platform generator to rebuild its 7 platforms using a req/ack handshake.
- Freezes character physics until the new platform set is stable.
- Sits between the character physics block and the platform generator; the VGA offset logic also consumes camera_y.

Parameters:
- POS_W, 14, width of absolute Y position.
- CAM_W, 5, width of camera index.
- SCREEN_H, 480, lines per camera screen.
- MAX_CAM, 31, highest legal camera index.
- MARGIN, 16, hysteresis in lines beyond a screen edge before scrolling.
- SETTLE_CYC, 4, sys_clk cycles freeze stays asserted after ack.
- ACK_TIMEOUT, 255, max sys_clk cycles waiting for regen_ack.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset.
- char_tick  in  1  one-cycle enable, once per physics step.
- abs_char_y  in  POS_W  character absolute Y; up is positive.
- regen_ack  in  1  platform generator finished rebuild.
- camera_y  out  CAM_W  current camera index.
- cam_base  out  POS_W  camera_y*SCREEN_H.
- regen_req  out  1  rebuild request.
- scroll_dir  out  1  1=up, 0=down; valid while regen_req is high.
- freeze  out  1  hold character physics.
- timeout_err  out  1  sticky ack-timeout flag.

Interface decision: one clock, sys_clk; sys_rst_n is asynchronous, active-low.

Behaviour:
- Reset values: camera_y=0, cam_base=0, regen_req=0, scroll_dir=0, freeze=0, timeout_err=0; state IDLE.
- Reset mid-handshake aborts everything immediately and returns to these values.
- cam_base is never computed by multiplication. It is updated by +/-SCREEN_H in the same cycle camera_y steps.
- Compare widths are POS_W+1 to avoid overflow: top = cam_base+SCREEN_H+MARGIN; bottom = cam_base-MARGIN.
- State IDLE:
  - Act only on char_tick.
  - If abs_char_y >= top and camera_y<MAX_CAM, go to REQ with dir=up.
  - Else if camera_y>0 and abs_char_y+MARGIN < cam_base, go to REQ with dir=down.
  - Otherwise stay in IDLE.
  - At camera_y=0 there is never a down scroll; at MAX_CAM there is never an up scroll.
- On the IDLE->REQ transition edge, registered:
  - camera_y and cam_base step.
  - scroll_dir is set.
  - regen_req=1 and freeze=1.
  - The new camera_y is visible the cycle after the tick.
- State REQ:
  - regen_req holds until regen_ack is sampled high. regen_ack is ignored while regen_req=0.
  - regen_ack sampled high: regen_req=0 next cycle; go to SETTLE.
  - ACK_TIMEOUT cycles without ack: regen_req=0, timeout_err=1 (sticky until reset); go to SETTLE.
- State SETTLE:
  - Count SETTLE_CYC cycles, then freeze=0 and return to IDLE.
  - char_tick is ignored in REQ and SETTLE.
- Multi-screen moves: one step per REQ/SETTLE round. Re-evaluation happens at the next char_tick in IDLE.
- Latency, tick to freeze release: 1 + ack wait + SETTLE_CYC cycles.
- Simultaneous char_tick and regen_ack in IDLE: the ack is ignored.

Optional Feature:
- Macro: CAMERA_FALL_CNT_EN.
- Defined:
  - Adds output fall_cnt [7:0], reset 0.
  - Increments on each down-scroll REQ entry; saturates at 255.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Decomposition:
- Shared package:
  - constants SCREEN_H, POS_W, CAM_W, MAX_CAM (also used by platform generator and VGA offset).
  - state typedef IDLE/REQ/SETTLE.
- One natural sub-module: regen_handshake.
  - Owns regen_req, the ack-timeout counter and timeout_err.
  - Start pulse in, done pulse out.

Test Plan:
- Reset, abs_char_y=100, tick -> camera_y=0, cam_base=0, freeze=0, regen_req=0.
- abs_char_y=496 (=480+16), tick -> next cycle camera_y=1, cam_base=480, regen_req=1, scroll_dir=1, freeze=1; ack after 3 cycles -> req drops; freeze drops 4 cycles later.
- abs_char_y=495 at camera 0 -> no scroll (hysteresis); at camera 1, abs_char_y=463 -> down scroll to camera 0, cam_base=0; at camera 0, abs_char_y=0 -> no scroll.
- No ack for 255 cycles -> regen_req=0, timeout_err=1, freeze releases after settle; timeout_err stays 1 until reset.
- abs_char_y=1500 from camera 0 -> three successive rounds to camera_y=3, cam_base=1440; ticks during REQ/SETTLE cause no extra step.
- With CAMERA_FALL_CNT_EN: two down scrolls -> fall_cnt=2. Assert sys_rst_n low mid-REQ -> all outputs return to reset values asynchronously.
